// File: rtl/cdc_fifo_pkg.sv
// Shared constants for the CDC FIFO blocks: output buffer depth and the
// width of the counter that tracks how many words that buffer holds.
package cdc_fifo_pkg;

  localparam int OCCUPANCY_WIDTH     = 2;
  localparam int OUTPUT_BUFFER_DEPTH = 2;

endpackage

// File: rtl/cdc_sync_bus.sv
// Plain multi-flop synchroniser for a Gray-coded bus crossing into this clock
// domain. Only the block reset touches the chain.
module cdc_sync_bus #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] source,
  output logic [WIDTH-1:0] synced
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_chain [STAGES];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) sync_chain[i] <= '0;
    end else begin
      sync_chain[0] <= source;
      for (int i = 1; i < STAGES; i++) sync_chain[i] <= sync_chain[i-1];
    end
  end

  assign synced = sync_chain[STAGES-1];

endmodule

// File: rtl/cdc_fifo_read_port.sv
// Read-domain half of the CDC FIFO: write-pointer synchroniser, read pointer,
// empty flag, RAM read issue and a 2-entry output buffer for full throughput.
module cdc_fifo_read_port
  import cdc_fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] write_address_gray,
  output logic [ADDRESS_WIDTH-1:0] read_address_gray,
  output logic [ADDRESS_WIDTH-1:0] read_address,
  output logic                     memory_read_enable,
  input  logic [DATA_WIDTH-1:0]    memory_read_data,
  output logic [DATA_WIDTH-1:0]    read_data,
  output logic                     read_valid,
  input  logic                     read_ready,
  output logic                     empty
);

  // Handshake: a word transfers at a clock edge where read_valid and
  // read_ready are both high; read_valid never depends on read_ready.

  function automatic logic [ADDRESS_WIDTH-1:0] gray_to_binary(
    input logic [ADDRESS_WIDTH-1:0] gray
  );
    logic [ADDRESS_WIDTH-1:0] binary;
    binary[ADDRESS_WIDTH-1] = gray[ADDRESS_WIDTH-1];
    for (int i = ADDRESS_WIDTH - 2; i >= 0; i--) binary[i] = binary[i+1] ^ gray[i];
    return binary;
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] binary_to_gray(
    input logic [ADDRESS_WIDTH-1:0] binary
  );
    return binary ^ (binary >> 1);
  endfunction

  logic [ADDRESS_WIDTH-1:0]   write_gray_sync;
  logic [ADDRESS_WIDTH-1:0]   write_address_sync;
  logic [ADDRESS_WIDTH-1:0]   read_address_next;
  logic [OCCUPANCY_WIDTH-1:0] occupancy;
  logic [OCCUPANCY_WIDTH:0]   pending;
  logic                       in_flight;
  logic                       pop;
  logic                       fetch;
  logic                       head;
  logic                       tail;
  logic [DATA_WIDTH-1:0]      buffer [OUTPUT_BUFFER_DEPTH];

  cdc_sync_bus #(
    .WIDTH  (ADDRESS_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_write_pointer_sync (
    .clock  (clock),
    .reset  (reset),
    .source (write_address_gray),
    .synced (write_gray_sync)
  );

  assign write_address_sync = gray_to_binary(write_gray_sync);
  assign empty              = (read_address == write_address_sync);
  assign read_valid         = (occupancy != '0);
  assign read_data          = buffer[head];
  assign pop                = read_valid & read_ready;
  assign read_address_next  = read_address + ADDRESS_WIDTH'(1);

  // Words buffered plus the word in the RAM pipe, less the one leaving now,
  // must stay below the buffer depth so a fetched word always finds a slot.
  assign pending = {1'b0, occupancy}
                 + {{OCCUPANCY_WIDTH{1'b0}}, in_flight}
                 - {{OCCUPANCY_WIDTH{1'b0}}, pop};
  assign fetch   = !empty && (pending < (OCCUPANCY_WIDTH+1)'(OUTPUT_BUFFER_DEPTH));
  assign memory_read_enable = fetch;

  always_ff @(posedge clock) begin
    if (!reset) begin
      read_address      <= '0;
      read_address_gray <= '0;
      in_flight         <= 1'b0;
      occupancy         <= '0;
      head              <= 1'b0;
      tail              <= 1'b0;
    end else begin
      in_flight <= fetch;
      if (fetch) begin
        read_address      <= read_address_next;
        read_address_gray <= binary_to_gray(read_address_next);
      end
      if (in_flight) tail <= ~tail;
      if (pop)       head <= ~head;
      occupancy <= occupancy + OCCUPANCY_WIDTH'(in_flight) - OCCUPANCY_WIDTH'(pop);
    end
  end

  // RAM data lands in the buffer the cycle it arrives; contents need no reset.
  always_ff @(posedge clock) begin
    if (in_flight) buffer[tail] <= memory_read_data;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(in_flight && !pop && occupancy == OCCUPANCY_WIDTH'(OUTPUT_BUFFER_DEPTH)));

  a_occupancy_range: assert property (@(posedge clock) disable iff (!reset)
    occupancy <= OCCUPANCY_WIDTH'(OUTPUT_BUFFER_DEPTH));

endmodule

// File: tb/tb_cdc_fifo_read_port.sv
// Bench for cdc_fifo_read_port: models the write side and a registered-read RAM,
// scoreboards popped data and issued RAM addresses against expected queues.
module tb_cdc_fifo_read_port;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] write_address_gray;
  logic [AW-1:0] read_address_gray;
  logic [AW-1:0] read_address;
  logic          memory_read_enable;
  logic [DW-1:0] memory_read_data;
  logic [DW-1:0] read_data;
  logic          read_valid;
  logic          read_ready;
  logic          empty;

  logic [DW-1:0] ram [16];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            wr_ptr;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] held_word;

  cdc_fifo_read_port #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .SYNC_STAGES   (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .write_address_gray (write_address_gray),
    .read_address_gray  (read_address_gray),
    .read_address       (read_address),
    .memory_read_enable (memory_read_enable),
    .memory_read_data   (memory_read_data),
    .read_data          (read_data),
    .read_valid         (read_valid),
    .read_ready         (read_ready),
    .empty              (empty)
  );

  // clock / reset block
  always #5 clock = ~clock;

  // RAM with one cycle of read latency
  always @(posedge clock) begin
    if (memory_read_enable) memory_read_data <= ram[read_address];
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // driver tasks
  task automatic push_word(input logic [DW-1:0] data);
    logic [31:0] p;
    p = 32'(wr_ptr);
    ram[p[3:0]] = data;
    exp_q.push_back(data);
    addr_q.push_back(p[3:0]);
    wr_ptr = (wr_ptr + 1) % 16;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    read_ready = 1'b0;
    write_address_gray = '0;
    exp_q.delete();
    addr_q.delete();
    wr_ptr = 0;
    step(3);
    reset = 1'b1;
    step(1);
  endtask

  task automatic wait_until_valid(input int max_cycles);
    int n = 0;
    while (!read_valid && n < max_cycles) begin
      step(1);
      n++;
    end
    check("wait_valid", 32'(read_valid), 32'd1);
  endtask

  task automatic wait_drained(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step(1);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard monitors, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && read_valid === 1'b1 && read_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'(read_data), 32'hFFFF_FFFF);
        end else begin
          check("pop_data", 32'(read_data), 32'(exp_q.pop_front()));
        end
      end
      if (reset === 1'b1 && memory_read_enable === 1'b1) begin
        if (addr_q.size() == 0) begin
          check("unexpected_fetch", 32'(read_address), 32'hFFFF_FFFF);
        end else begin
          check("fetch_address", 32'(read_address), 32'(addr_q.pop_front()));
        end
      end
    end
  end

  initial begin
    wr_ptr = 0;
    read_ready = 1'b0;
    memory_read_data = '0;
    for (int i = 0; i < 16; i++) ram[i] = '0;

    // reset with a nonzero write pointer at the input
    reset = 1'b0;
    write_address_gray = 4'b0011;
    step(3);
    check("rst_read_address", 32'(read_address), 32'h0);
    check("rst_read_gray", 32'(read_address_gray), 32'h0);
    check("rst_read_valid", 32'(read_valid), 32'h0);
    check("rst_mem_en", 32'(memory_read_enable), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    write_address_gray = 4'b0000;
    reset = 1'b1;
    step(2);

    // single word: pointer 0 -> 1
    push_word(8'hA5);
    write_address_gray = 4'b0001;
    step(1);
    check("single_empty_still", 32'(empty), 32'h1);
    step(1);
    check("single_empty_fall", 32'(empty), 32'h0);
    check("single_fetch", 32'(memory_read_enable), 32'h1);
    check("single_fetch_addr", 32'(read_address), 32'h0);
    step(1);
    check("single_addr_inc", 32'(read_address), 32'h1);
    check("single_valid_early", 32'(read_valid), 32'h0);
    check("single_empty_again", 32'(empty), 32'h1);
    step(1);
    check("single_valid", 32'(read_valid), 32'h1);
    check("single_data", 32'(read_data), 32'hA5);
    read_ready = 1'b1;
    step(1);
    read_ready = 1'b0;
    check("single_drained", 32'(read_valid), 32'h0);

    // back-to-back: five words, ready held high
    do_reset();
    for (int i = 0; i < 5; i++) push_word(8'h10 + 8'(i));
    write_address_gray = 4'b0111;
    read_ready = 1'b1;
    wait_until_valid(10);
    for (int k = 0; k < 5; k++) begin
      check("b2b_valid", 32'(read_valid), 32'h1);
      step(1);
    end
    check("b2b_valid_end", 32'(read_valid), 32'h0);
    check("b2b_empty", 32'(empty), 32'h1);
    check("b2b_read_address", 32'(read_address), 32'h5);
    read_ready = 1'b0;

    // backpressure: four words, consumer stalled
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'h30 + 8'(i));
    write_address_gray = 4'b0110;
    step(8);
    check("bp_fetch_count", 32'(read_address), 32'h2);
    check("bp_occupancy", 32'(dut.occupancy), 32'h2);
    check("bp_valid", 32'(read_valid), 32'h1);
    check("bp_no_fetch", 32'(memory_read_enable), 32'h0);
    check("bp_data", 32'(read_data), 32'h30);
    held_word = read_data;
    step(2);
    check("bp_data_stable", 32'(read_data), 32'(held_word));
    read_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_drain_valid", 32'(read_valid), 32'h1);
      step(1);
    end
    check("bp_drain_end", 32'(read_valid), 32'h0);
    check("bp_read_address", 32'(read_address), 32'h4);
    read_ready = 1'b0;

    // wrap: advance both pointers to 14, then write four more
    do_reset();
    for (int i = 0; i < 14; i++) push_word(8'h40 + 8'(i));
    write_address_gray = 4'b1001;
    read_ready = 1'b1;
    wait_drained(40);
    step(2);
    check("wrap_pre_address", 32'(read_address), 32'hE);
    check("wrap_pre_gray", 32'(read_address_gray), 32'h9);
    check("wrap_pre_empty", 32'(empty), 32'h1);
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
    write_address_gray = 4'b0011;
    wait_drained(20);
    step(2);
    check("wrap_address", 32'(read_address), 32'h2);
    check("wrap_gray", 32'(read_address_gray), 32'h3);
    check("wrap_empty", 32'(empty), 32'h1);
    check("wrap_valid", 32'(read_valid), 32'h0);
    read_ready = 1'b0;

    // reset in the middle of streaming, with a word in the RAM pipe
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'h70 + 8'(i));
    write_address_gray = 4'b0110;
    read_ready = 1'b1;
    wait_until_valid(10);
    check("mid_in_flight", 32'(dut.in_flight), 32'h1);
    check("mid_occupancy", 32'(dut.occupancy), 32'h1);
    reset = 1'b0;
    read_ready = 1'b0;
    write_address_gray = '0;
    exp_q.delete();
    addr_q.delete();
    wr_ptr = 0;
    step(1);
    check("mid_valid", 32'(read_valid), 32'h0);
    check("mid_mem_en", 32'(memory_read_enable), 32'h0);
    check("mid_read_address", 32'(read_address), 32'h0);
    check("mid_read_gray", 32'(read_address_gray), 32'h0);
    check("mid_occupancy_clr", 32'(dut.occupancy), 32'h0);
    step(1);
    reset = 1'b1;
    read_ready = 1'b1;
    step(6);
    check("mid_no_stale", 32'(read_valid), 32'h0);
    check("mid_empty", 32'(empty), 32'h1);
    read_ready = 1'b0;

    check("queues_drained", 32'(exp_q.size() + addr_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
